// File: rtl/hypot_rr_arbiter.sv
// rtl/hypot_rr_arbiter.sv - round-robin arbiter sequencing one shared isqrt(x*x+y*y) engine
module hypot_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] x_in,
  input  logic [NREQ*W-1:0] y_in,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_err,
  output logic              eng_start,
  output logic [W-1:0]      eng_x,
  output logic [W-1:0]      eng_y,
  input  logic              eng_done,
  input  logic [W-1:0]      eng_result
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   win;
  logic [TW-1:0]   timer;
  logic [PW-1:0]   win_idx;
  logic            found;
  logic [NREQ-1:0] win_onehot;
  logic [PW-1:0]   ptr_next;
  int              scan_idx;

  // Scan starting at rr_ptr so the last winner ends up with lowest priority.
  always_comb begin
    found      = 1'b0;
    win_idx    = '0;
    scan_idx   = 0;
    win_onehot = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req[scan_idx]) begin
        found   = 1'b1;
        win_idx = PW'(scan_idx);
      end
    end
    win_onehot[win_idx] = 1'b1;
  end

  assign ptr_next = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      win       <= '0;
      timer     <= '0;
      grant     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      eng_start <= 1'b0;
      eng_x     <= '0;
      eng_y     <= '0;
    end else begin
      eng_start <= 1'b0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ena && found) begin
            win       <= win_idx;
            eng_x     <= x_in[int'(win_idx)*W +: W];
            eng_y     <= y_in[int'(win_idx)*W +: W];
            grant     <= win_onehot;
            eng_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          // A done arriving on the watchdog's last cycle still counts as success.
          if (eng_done) begin
            rsp_data  <= eng_result;
            rsp_valid <= grant;
            state     <= S_RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            rsp_err   <= 1'b1;
            rsp_valid <= grant;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          grant  <= '0;
          rr_ptr <= ptr_next;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hypot_rr_arbiter.sv
// tb/tb_hypot_rr_arbiter.sv - randomized and directed bench for hypot_rr_arbiter
module tb_hypot_rr_arbiter;
  localparam int NREQ = 4;
  localparam int W = 8;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*W-1:0] x_in = '0;
  logic [NREQ*W-1:0] y_in = '0;
  logic [NREQ-1:0] grant, rsp_valid;
  logic [W-1:0] rsp_data, eng_x, eng_y;
  logic rsp_err, eng_start;
  logic eng_done = 1'b0;
  logic [W-1:0] eng_result = '0;

  int n_pass = 0;
  int n_tot = 0;
  bit chk_on = 1'b0;
  bit noise = 1'b0;
  int lat_cfg = 3;
  int eng_cnt = 0;
  logic [W-1:0] cap_x = '0;
  logic [W-1:0] cap_y = '0;

  always #5 clk = ~clk;

  hypot_rr_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .x_in(x_in), .y_in(y_in),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
    .eng_done(eng_done), .eng_result(eng_result)
  );

  function automatic logic [W-1:0] isqrt(input logic [W-1:0] a, input logic [W-1:0] b);
    int v;
    int r;
    v = int'(a) * int'(a) + int'(b) * int'(b);
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return W'(r);
  endfunction

  // Stand-in engine: fixed or random latency, 0 = never finishes, plus optional stray dones.
  always @(negedge clk) begin
    eng_done <= 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eng_done   <= 1'b1;
        eng_result <= isqrt(cap_x, cap_y);
      end
    end else if (noise && $urandom_range(0, 15) == 0) begin
      eng_done   <= 1'b1;
      eng_result <= W'($urandom);
    end
    if (eng_start) begin
      cap_x <= eng_x;
      cap_y <= eng_y;
      if (lat_cfg >= 0) eng_cnt <= lat_cfg;
      else eng_cnt <= ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 8));
    end
  end

  // Reference model: one operation in flight, timed by the cycle numbers of grant and response.
  typedef struct {
    bit busy;
    int who;
    int gcyc;
    int rcyc;
    bit err;
    logic [W-1:0] res;
    logic [W-1:0] ex;
    logic [W-1:0] ey;
    int ptr;
    int cyc;
  } ms_t;

  ms_t m;

  function automatic ms_t mreset();
    ms_t s;
    s.busy = 1'b0; s.who = 0; s.gcyc = 0; s.rcyc = -1; s.err = 1'b0;
    s.res = '0; s.ex = '0; s.ey = '0; s.ptr = 0; s.cyc = 0;
    return s;
  endfunction

  function automatic ms_t mstep(ms_t s, logic [NREQ-1:0] rq, logic en, logic dn,
                                logic [W-1:0] rs, logic [NREQ*W-1:0] xs, logic [NREQ*W-1:0] ys);
    bit found;
    found = 1'b0;
    s.cyc++;
    if (s.busy) begin
      if (s.rcyc >= 0) begin
        if (s.cyc == s.rcyc + 1) begin
          s.busy = 1'b0;
          s.ptr  = (s.who + 1) % NREQ;
        end
      end else if (s.cyc >= s.gcyc + 2) begin
        if (dn) begin
          s.rcyc = s.cyc; s.res = rs; s.err = 1'b0;
        end else if (s.cyc == s.gcyc + TIMEOUT + 1) begin
          s.rcyc = s.cyc; s.res = '0; s.err = 1'b1;
        end
      end
    end else if (en && rq != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && rq[(s.ptr + k) % NREQ]) begin
          found = 1'b1;
          s.who = (s.ptr + k) % NREQ;
        end
      end
      s.busy = 1'b1;
      s.gcyc = s.cyc;
      s.rcyc = -1;
      s.ex   = xs[s.who*W +: W];
      s.ey   = ys[s.who*W +: W];
    end
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= mreset();
    else m <= mstep(m, req, ena, eng_done, eng_result, x_in, y_in);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic compare_model();
    logic [NREQ-1:0] oh;
    bit rv;
    oh = '0;
    if (m.busy) oh[m.who] = 1'b1;
    rv = m.busy && (m.cyc == m.rcyc);
    chk("grant", grant, oh);
    chk("eng_start", eng_start, m.busy && (m.cyc == m.gcyc));
    chk("rsp_valid", rsp_valid, rv ? oh : '0);
    chk("rsp_data", rsp_data, rv ? m.res : '0);
    chk("rsp_err", rsp_err, rv && m.err);
    chk("eng_x", eng_x, m.ex);
    chk("eng_y", eng_y, m.ey);
  endtask

  task automatic step();
    @(negedge clk);
    if (chk_on) compare_model();
  endtask

  task automatic setop(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
    x_in[i*W +: W] = x;
    y_in[i*W +: W] = y;
  endtask

  task automatic await_rsp(input string nm, input int who, input logic [W-1:0] d, input logic e);
    int n;
    bit gseen;
    n = 0;
    gseen = 1'b0;
    step();
    while (rsp_valid == '0 && n < 200) begin
      if (!gseen && grant != '0) begin
        gseen = 1'b1;
        chk({nm, "_grant"}, grant, 32'(1) << who);
      end
      step();
      n++;
    end
    chk({nm, "_rsp_valid"}, rsp_valid, 32'(1) << who);
    chk({nm, "_rsp_data"}, rsp_data, d);
    chk({nm, "_rsp_err"}, rsp_err, e);
  endtask

  task automatic await_start();
    int n;
    n = 0;
    while (!eng_start && n < 20) begin
      step();
      n++;
    end
    chk("eng_start_seen", eng_start, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] fair_exp [NREQ];
    int k;
    int cnt;
    fair_exp[0] = 8'd2; fair_exp[1] = 8'd3; fair_exp[2] = 8'd5; fair_exp[3] = 8'd6;

    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    step();
    chk("reset_grant", grant, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_eng_x", eng_x, 0);
    rst_n = 1'b1;
    ena = 1'b1;

    // contention from rr_ptr = 0, then prove the pointer landed on 3
    setop(0, 6, 8); setop(2, 5, 12); req = 4'b0101;
    await_rsp("t2a", 0, 10, 0); req[0] = 1'b0;
    await_rsp("t2b", 2, 13, 0); req[2] = 1'b0;
    setop(0, 1, 1); setop(3, 0, 0); req = 4'b1001;
    await_rsp("t2ptr", 3, 0, 0); req[3] = 1'b0;
    await_rsp("t2c", 0, 1, 0); req[0] = 1'b0;

    // single request
    setop(1, 3, 4); req = 4'b0010;
    await_rsp("t1", 1, 5, 0); req = '0;
    chk("t1_eng_x", eng_x, 3);
    chk("t1_eng_y", eng_y, 4);

    // fairness with every requester held high
    do_reset();
    for (int i = 0; i < NREQ; i++) setop(i, W'(i + 1), W'(i + 2));
    req = '1;
    for (int i = 0; i < NREQ; i++) await_rsp($sformatf("t3_%0d", i), i, fair_exp[i], 0);
    req = '0;

    // watchdog expiry, then a normal op
    lat_cfg = 0;
    setop(3, 9, 9); req = 4'b1000;
    await_start();
    k = 0;
    while (rsp_valid == '0 && k < 200) begin
      step();
      k++;
    end
    chk("t4_latency", k, 65);
    chk("t4_rsp_valid", rsp_valid, 4'b1000);
    chk("t4_rsp_data", rsp_data, 0);
    chk("t4_rsp_err", rsp_err, 1);
    req = '0;
    lat_cfg = 2;
    setop(1, 8, 15); req = 4'b0010;
    await_rsp("t4_next", 1, 17, 0); req = '0;

    // reset while waiting on the engine; its late done must be ignored
    lat_cfg = 6;
    setop(2, 7, 24); req = 4'b0100;
    await_start();
    step();
    step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req = '0;
    #1;
    chk("t5_grant", grant, 0);
    chk("t5_eng_x", eng_x, 0);
    chk("t5_eng_y", eng_y, 0);
    step();
    step();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rsp_valid != '0) cnt++;
    end
    chk("t5_no_rsp", cnt, 0);

    // ena gating
    lat_cfg = 2;
    ena = 1'b0;
    setop(3, 12, 16); req = 4'b1000;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t6_gated", grant, 0);
    end
    ena = 1'b1;
    step();
    chk("t6_grant", grant, 4'b1000);
    await_rsp("t6", 3, 20, 0); req = '0;

    // randomized traffic
    noise = 1'b1;
    lat_cfg = -1;
    for (int c = 0; c < 4000; c++) begin
      step();
      ena = ($urandom_range(0, 15) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            setop(i, W'($urandom), W'($urandom));
            req[i] = 1'b1;
          end
        end else if (!grant[i] && $urandom_range(0, 63) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;
    noise = 1'b0;
    repeat (100) step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
